marquee_scroll_ctrl: RTL and testbench

//  Controller for the character-rotation display datapath. Loads a message over a

---
 rtl/marquee_scroll_ctrl_pkg.sv | 17 +
 rtl/marquee_scroll_ctrl_if.sv | 14 +
 rtl/marquee_scroll_ctrl_prescaler.sv | 28 ++
 rtl/marquee_scroll_ctrl.sv | 121 ++++++++++++
 tb/tb_marquee_scroll_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/marquee_scroll_ctrl_pkg.sv
// marquee_pkg: shared types and constants for the marquee scroll controller.
//   state_t    - controller FSM states
//   CHAR_W     - character width in bits
//   SPACE      - blank character used to fill the message buffer
//   blank_fill - all-spaces vector wide enough for any supported buffer depth
//                (MSG_CHARS <= MAX_CHARS); users truncate to their own width
package marquee_pkg;
  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] SPACE = 8'h20;
  localparam int MAX_CHARS = 256;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE} state_t;

  function automatic logic [MAX_CHARS*CHAR_W-1:0] blank_fill();
    return {MAX_CHARS{SPACE}};
  endfunction
endpackage

// File: rtl/marquee_scroll_ctrl_if.sv
// marquee_scroll_ctrl_if: valid/ready character write stream.
//   wr_valid - character present (master)
//   wr_char  - ASCII character (master)
//   wr_last  - final character of the message (master)
//   wr_ready - controller accepts a character this cycle (slave)
interface marquee_scroll_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       wr_last;

  modport master (output wr_valid, wr_char, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_char, wr_last, output wr_ready);
endinterface

// File: rtl/marquee_scroll_ctrl_prescaler.sv
// scroll_prescaler: programmable tick generator for the scroll rate.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_en         - count enable (low holds the count)
//   i_clr        - force count to zero, suppresses tick
//   i_div_val    - period is i_div_val+1 enabled clocks
//   o_tick       - combinational, high in the cycle the count reaches i_div_val
module scroll_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div_val,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt;

  // >= rather than == so lowering i_div_val below the current count fires
  // on the next clock instead of running all the way round the counter.
  assign o_tick = i_en && !i_clr && (r_cnt >= i_div_val);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)  r_cnt <= '0;
    else if (o_tick)     r_cnt <= '0;
    else if (i_en)       r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/marquee_scroll_ctrl.sv
// marquee_scroll_ctrl: loads a message over a byte stream, then rotates it one
// character per prescaler tick and presents the leading WIN_CHARS characters.
//   i_clk, i_rst - clock, synchronous active-high reset
//   wr_if        - character write stream (slave)
//   i_clear      - abort, blank buffer, return to idle
//   i_div_val    - scroll period = i_div_val+1 clocks
//   i_dir        - 0 rotate left, 1 rotate right
//   i_pause      - freeze scrolling and prescaler
//   o_window     - buffer chars 0..WIN_CHARS-1, char 0 in the MSBs
//   o_running    - high while scrolling
//   o_wrap       - one-cycle pulse when the rotation offset returns to 0
module marquee_scroll_ctrl
  import marquee_pkg::*;
#(
  parameter int MSG_CHARS = 32,
  parameter int WIN_CHARS = 16,
  parameter int DIV_W     = 24
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  marquee_scroll_ctrl_if.slave        wr_if,
  input  logic                        i_clear,
  input  logic [DIV_W-1:0]            i_div_val,
  input  logic                        i_dir,
  input  logic                        i_pause,
  output logic [CHAR_W*WIN_CHARS-1:0] o_window,
  output logic                        o_running,
  output logic                        o_wrap
);
  localparam int BUF_W = CHAR_W * MSG_CHARS;
  localparam int PTR_W = $clog2(MSG_CHARS);
  localparam int WIN_W = CHAR_W * WIN_CHARS;
  localparam logic [BUF_W-1:0] BLANK = BUF_W'(blank_fill());

  state_t             r_state;
  logic [BUF_W-1:0]   r_buf;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_offset;
  logic               r_wr_ready;
  logic               r_running;
  logic               r_wrap;

  logic               w_fire;
  logic               w_tick;
  logic               w_pre_en;
  logic               w_pre_clr;
  logic [PTR_W-1:0]   w_next_off;
  logic [$clog2(BUF_W)-1:0] w_wr_lsb;

  assign w_fire     = wr_if.wr_valid && r_wr_ready && !i_clear;
  assign w_pre_en   = (r_state == S_RUN) && !i_pause;
  // Holding the count at zero outside RUN/PAUSE makes every entry to RUN
  // start a fresh period.
  assign w_pre_clr  = i_clear || (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_next_off = i_dir ? r_offset - 1'b1 : r_offset + 1'b1;
  // Char i sits at bit CHAR_W*(MSG_CHARS-1-i); with a power-of-two depth
  // that is just the inverted index scaled by CHAR_W.
  assign w_wr_lsb   = {~r_wr_ptr, {$clog2(CHAR_W){1'b0}}};

  scroll_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (w_pre_en),
    .i_clr     (w_pre_clr),
    .i_div_val (i_div_val),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state    <= S_IDLE;
      r_buf      <= BLANK;
      r_wr_ptr   <= '0;
      r_offset   <= '0;
      r_wr_ready <= 1'b1;
      r_running  <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        // IDLE always has r_wr_ptr == 0, so both load states share one path.
        S_IDLE, S_LOAD: begin
          if (w_fire) begin
            r_buf[w_wr_lsb +: CHAR_W] <= wr_if.wr_char;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (wr_if.wr_last || r_wr_ptr == PTR_W'(MSG_CHARS - 1)) begin
              r_state    <= S_RUN;
              r_running  <= 1'b1;
              r_wr_ready <= 1'b0;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_RUN: begin
          if (i_pause) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            r_buf    <= i_dir ? {r_buf[CHAR_W-1:0], r_buf[BUF_W-1:CHAR_W]}
                              : {r_buf[BUF_W-CHAR_W-1:0], r_buf[BUF_W-1 -: CHAR_W]};
            r_offset <= w_next_off;
            r_wrap   <= (w_next_off == '0);
          end
        end
        S_PAUSE: begin
          if (!i_pause) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_if.wr_ready = r_wr_ready;
  assign o_window       = r_buf[BUF_W-1 -: WIN_W];
  assign o_running      = r_running;
  assign o_wrap         = r_wrap;
endmodule

// File: tb/tb_marquee_scroll_ctrl.sv
// Bench for marquee_scroll_ctrl. The reference keeps the message unrotated
// plus a rotation offset; the expected window is read out modulo MSG.
module tb_marquee_scroll_ctrl;
  localparam int MSG = 32;
  localparam int WIN = 16;
  localparam int DW  = 24;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_clear = 1'b0;
  logic [DW-1:0]    i_div_val = '0;
  logic             i_dir = 1'b0;
  logic             i_pause = 1'b0;
  logic [8*WIN-1:0] o_window;
  logic             o_running;
  logic             o_wrap;

  marquee_scroll_ctrl_if wr_if();

  marquee_scroll_ctrl #(.MSG_CHARS(MSG), .WIN_CHARS(WIN), .DIV_W(DW)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .wr_if     (wr_if),
    .i_clear   (i_clear),
    .i_div_val (i_div_val),
    .i_dir     (i_dir),
    .i_pause   (i_pause),
    .o_window  (o_window),
    .o_running (o_running),
    .o_wrap    (o_wrap)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 load, 2 run, 3 pause.
  int           m_mode, m_ptr, m_off, m_cnt;
  bit           m_wrap;
  byte unsigned m_msg[MSG];
  byte unsigned t_msg[MSG];

  function automatic logic [8*WIN-1:0] exp_window();
    logic [8*WIN-1:0] r;
    for (int i = 0; i < WIN; i++) r[8*WIN-1-8*i -: 8] = m_msg[(i + m_off) % MSG];
    return r;
  endfunction

  task automatic model_step();
    if (i_rst || i_clear) begin
      m_mode = 0; m_ptr = 0; m_off = 0; m_cnt = 0; m_wrap = 0;
      for (int i = 0; i < MSG; i++) m_msg[i] = 8'h20;
    end else begin
      m_wrap = 0;
      case (m_mode)
        0, 1: if (wr_if.wr_valid) begin
          m_msg[m_ptr] = wr_if.wr_char;
          if (wr_if.wr_last || m_ptr == MSG-1) begin m_mode = 2; m_cnt = 0; end
          else m_mode = 1;
          m_ptr = (m_ptr + 1) % MSG;
        end
        2: if (i_pause) m_mode = 3;
           else if (m_cnt >= int'(i_div_val)) begin
             m_cnt = 0;
             m_off = i_dir ? (m_off + MSG - 1) % MSG : (m_off + 1) % MSG;
             m_wrap = (m_off == 0);
           end else m_cnt++;
        default: if (!i_pause) m_mode = 2;
      endcase
    end
  endtask

  task automatic clk1();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clks(input int n);
    repeat (n) clk1();
  endtask

  task automatic do_clear();
    i_clear = 1'b1; clk1(); i_clear = 1'b0;
  endtask

  // Clears, then writes n random printable chars back to back; returns #1
  // after the edge that accepted the last one.
  task automatic load_random(input int n, input bit with_last);
    do_clear();
    for (int i = 0; i < MSG; i++) t_msg[i] = 8'h20;
    for (int i = 0; i < n; i++) begin
      t_msg[i] = 8'($urandom_range(33, 126));
      wr_if.wr_valid = 1'b1; wr_if.wr_char = t_msg[i];
      wr_if.wr_last = with_last && (i == n-1);
      clk1();
    end
    wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; wr_if.wr_valid = 1'b0; wr_if.wr_char = 8'h00; wr_if.wr_last = 1'b0;
    clks(3);
    i_rst = 1'b0;
    checks++; if (o_window !== {WIN{8'h20}}) begin errors++; $display("FAIL reset_window got=%h exp=%h", o_window, {WIN{8'h20}}); end
    checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", wr_if.wr_ready); end
    checks++; if (o_running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", o_running); end
    checks++; if (o_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", o_wrap); end
  endtask

  task automatic test_load_short();
    logic [8*WIN-1:0] exp;
    exp = {8'h41, 8'h42, {(WIN-2){8'h20}}};
    i_div_val = 24'd1000; i_dir = 1'b0;
    wr_if.wr_valid = 1'b1; wr_if.wr_char = 8'h41; wr_if.wr_last = 1'b0; clk1();
    checks++; if (o_running !== 1'b0 || wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL load_mid running=%b ready=%b exp 0/1", o_running, wr_if.wr_ready); end
    wr_if.wr_char = 8'h42; wr_if.wr_last = 1'b1; clk1();
    wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    checks++; if (o_running !== 1'b1 || wr_if.wr_ready !== 1'b0) begin errors++; $display("FAIL load_done running=%b ready=%b exp 1/0", o_running, wr_if.wr_ready); end
    checks++; if (o_window !== exp) begin errors++; $display("FAIL load_window got=%h exp=%h", o_window, exp); end
    // A write while scrolling must be ignored.
    wr_if.wr_valid = 1'b1; wr_if.wr_char = 8'h5A; wr_if.wr_last = 1'b1; clk1();
    wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    checks++; if (o_window !== exp || o_running !== 1'b1) begin errors++; $display("FAIL ignored_write got=%h run=%b exp=%h run=1", o_window, o_running, exp); end
  endtask

  task automatic test_scroll_left();
    i_div_val = 24'd3; i_dir = 1'b0; i_pause = 1'b0;
    load_random(MSG, 1'b0);
    checks++; if (o_running !== 1'b1) begin errors++; $display("FAIL left_enter_run got=%b exp=1", o_running); end
    for (int c = 1; c <= 128; c++) begin
      clk1();
      checks++; if (o_window !== exp_window() || o_wrap !== m_wrap) begin errors++; $display("FAIL left_model c=%0d win=%h wrap=%b exp win=%h wrap=%b", c, o_window, o_wrap, exp_window(), m_wrap); end
      if (c == 3) begin checks++; if (o_window[127:120] !== t_msg[0]) begin errors++; $display("FAIL left_pretick got=%h exp=%h", o_window[127:120], t_msg[0]); end end
      if (c == 4) begin checks++; if (o_window[127:120] !== t_msg[1]) begin errors++; $display("FAIL left_first_tick got=%h exp=%h", o_window[127:120], t_msg[1]); end end
      if (c == 127) begin checks++; if (o_wrap !== 1'b0) begin errors++; $display("FAIL left_early_wrap got=%b exp=0", o_wrap); end end
      if (c == 128) begin
        checks++; if (o_wrap !== 1'b1) begin errors++; $display("FAIL left_wrap got=%b exp=1", o_wrap); end
        checks++; if (o_window[127:120] !== t_msg[0]) begin errors++; $display("FAIL left_wrap_char got=%h exp=%h", o_window[127:120], t_msg[0]); end
      end
    end
  endtask

  task automatic test_scroll_right();
    i_div_val = 24'd0; i_dir = 1'b1; i_pause = 1'b0;
    load_random(MSG, 1'b1);
    clk1();
    checks++; if (o_window[127:120] !== t_msg[MSG-1]) begin errors++; $display("FAIL right_first got=%h exp=%h", o_window[127:120], t_msg[MSG-1]); end
    clk1();
    checks++; if (o_window[127:120] !== t_msg[MSG-2]) begin errors++; $display("FAIL right_second got=%h exp=%h", o_window[127:120], t_msg[MSG-2]); end
    for (int c = 0; c < 100; c++) begin
      if ($urandom_range(0, 3) == 0) i_dir = ~i_dir;
      i_pause = ($urandom_range(0, 4) == 0);
      i_div_val = DW'($urandom_range(0, 2));
      clk1();
      checks++; if (o_window !== exp_window() || o_wrap !== m_wrap || o_running !== (m_mode == 2)) begin errors++; $display("FAIL dir_rand c=%0d win=%h wrap=%b run=%b exp win=%h wrap=%b", c, o_window, o_wrap, o_running, exp_window(), m_wrap); end
    end
    i_pause = 1'b0;
  endtask

  task automatic test_pause();
    i_div_val = 24'd3; i_dir = 1'b0; i_pause = 1'b0;
    load_random(MSG, 1'b0);
    clks(2);
    i_pause = 1'b1;
    for (int c = 0; c < 10; c++) begin
      clk1();
      checks++; if (o_window[127:120] !== t_msg[0] || o_running !== 1'b0) begin errors++; $display("FAIL pause_hold c=%0d char=%h run=%b exp=%h run=0", c, o_window[127:120], o_running, t_msg[0]); end
    end
    i_pause = 1'b0;
    clk1();
    checks++; if (o_running !== 1'b1 || o_window[127:120] !== t_msg[0]) begin errors++; $display("FAIL pause_resume run=%b char=%h exp run=1 char=%h", o_running, o_window[127:120], t_msg[0]); end
    clk1();
    checks++; if (o_window[127:120] !== t_msg[0]) begin errors++; $display("FAIL pause_early_tick got=%h exp=%h", o_window[127:120], t_msg[0]); end
    clk1();
    checks++; if (o_window[127:120] !== t_msg[1]) begin errors++; $display("FAIL pause_tick got=%h exp=%h", o_window[127:120], t_msg[1]); end
  endtask

  task automatic test_clear();
    i_div_val = 24'd0; i_dir = 1'b0; i_pause = 1'b0;
    load_random(MSG, 1'b0);
    clks(3);
    i_clear = 1'b1; i_pause = 1'b1;
    wr_if.wr_valid = 1'b1; wr_if.wr_char = 8'h51; wr_if.wr_last = 1'b1;
    clk1();
    i_clear = 1'b0; i_pause = 1'b0; wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    checks++; if (o_window !== {WIN{8'h20}}) begin errors++; $display("FAIL clear_window got=%h exp=%h", o_window, {WIN{8'h20}}); end
    checks++; if (o_running !== 1'b0 || wr_if.wr_ready !== 1'b1 || o_wrap !== 1'b0) begin errors++; $display("FAIL clear_state run=%b ready=%b wrap=%b exp 0/1/0", o_running, wr_if.wr_ready, o_wrap); end
    // Clear in idle together with a last-write: write dropped, stays idle.
    i_clear = 1'b1; wr_if.wr_valid = 1'b1; wr_if.wr_char = 8'h51; wr_if.wr_last = 1'b1;
    clk1();
    i_clear = 1'b0; wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
    clk1();
    checks++; if (o_window !== {WIN{8'h20}} || o_running !== 1'b0 || wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL clear_drops_write win=%h run=%b ready=%b exp spaces/0/1", o_window, o_running, wr_if.wr_ready); end
  endtask

  task automatic test_div_change();
    i_div_val = 24'd100; i_dir = 1'b0; i_pause = 1'b0;
    load_random(MSG, 1'b0);
    clks(50);
    checks++; if (o_window[127:120] !== t_msg[0]) begin errors++; $display("FAIL div_pre got=%h exp=%h", o_window[127:120], t_msg[0]); end
    i_div_val = 24'd5;
    clk1();
    checks++; if (o_window[127:120] !== t_msg[1]) begin errors++; $display("FAIL div_lowered_tick got=%h exp=%h", o_window[127:120], t_msg[1]); end
    clks(5);
    checks++; if (o_window[127:120] !== t_msg[1]) begin errors++; $display("FAIL div_hold got=%h exp=%h", o_window[127:120], t_msg[1]); end
    clk1();
    checks++; if (o_window[127:120] !== t_msg[2]) begin errors++; $display("FAIL div_period1 got=%h exp=%h", o_window[127:120], t_msg[2]); end
    clks(6);
    checks++; if (o_window[127:120] !== t_msg[3]) begin errors++; $display("FAIL div_period2 got=%h exp=%h", o_window[127:120], t_msg[3]); end
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 600; c++) begin
      i_clear        = ($urandom_range(0, 39) == 0);
      i_pause        = ($urandom_range(0, 5) == 0);
      i_dir          = 1'($urandom_range(0, 1));
      i_div_val      = DW'($urandom_range(0, 3));
      wr_if.wr_valid = 1'($urandom_range(0, 1));
      wr_if.wr_char  = 8'($urandom_range(33, 126));
      wr_if.wr_last  = ($urandom_range(0, 7) == 0);
      clk1();
      checks++; if (o_window !== exp_window() || o_wrap !== m_wrap || o_running !== (m_mode == 2) || wr_if.wr_ready !== (m_mode <= 1)) begin
        errors++; $display("FAIL random c=%0d win=%h wrap=%b run=%b rdy=%b exp win=%h wrap=%b mode=%0d", c, o_window, o_wrap, o_running, wr_if.wr_ready, exp_window(), m_wrap, m_mode);
      end
    end
    i_clear = 1'b0; i_pause = 1'b0; wr_if.wr_valid = 1'b0; wr_if.wr_last = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_short();
    test_scroll_left();
    test_scroll_right();
    test_pause();
    test_clear();
    test_div_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
